vga_layer_compositor: RTL and testbench

Parametrised successor to the two-player pixel colouring stage. It composites a background generator, one overlay layer (HUD bars, banners) and NUM_SPRITES prioritised sprite layers into one 12-bit RGB stream. Each sprite layer has colour-key transparency, a tint mode, and a frame-timed hit-flash. The block sits between the VGA timing counters, the sprite ROMs and the VGA output pins, with a fixed 2-cycle pipeline.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/sprite_flash_timer.sv | 39 +++
 rtl/vga_layer_compositor.sv | 125 ++++++++++++
 tb/tb_vga_layer_compositor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared colours, keys and helpers for the layered VGA pixel compositor.
package vga_pkg;

    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] PURPLE  = 12'hF0F;
    localparam logic [11:0] RED     = 12'hF00;

    localparam logic [11:0] KEY_C   = 12'h00C;
    localparam logic [11:0] KEY_D   = 12'h00D;
    localparam logic [11:0] KEY_F   = 12'h00F;
    localparam logic [11:0] OVL_KEY = 12'h0AF;

    typedef enum logic [1:0] {
        TINT_RAW    = 2'b00,
        TINT_SHIELD = 2'b01,
        TINT_RED    = 2'b10
    } tint_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic is_key(input logic [11:0] p);
        return (p == KEY_C) || (p == KEY_D) || (p == KEY_F);
    endfunction

endpackage

// File: rtl/sprite_flash_timer.sv
// Per-sprite hit-flash frame counter; a hit reloads it, frame_start counts it down.
module sprite_flash_timer #(
    parameter int FLASH_FRAMES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start_i,
    input  logic hit_i,
    output logic blink_o,
    output logic active_o
);

    logic [4:0] cnt_q, cnt_d;
    logic       active_q;

    always_comb begin
        cnt_d = cnt_q;
        if (hit_i) begin
            cnt_d = 5'(FLASH_FRAMES);
        end else if (frame_start_i && (cnt_q != 5'd0)) begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    // active tracks the counter it is registered alongside, so no lag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= (cnt_d != 5'd0);
        end
    end

    assign blink_o  = cnt_q[1];
    assign active_o = active_q;

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage compositor: background, overlay and prioritised keyed sprites.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES  = 2,
    parameter int SPR_W        = 128,
    parameter int SPR_H        = 128,
    parameter int ADDR_W       = 14,
    parameter int FLASH_FRAMES = 16,
    parameter int HORIZON      = 394
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bright,
    input  logic [9:0]                  hCount,
    input  logic [9:0]                  vCount,
    input  logic                        frame_start,
    input  logic [NUM_SPRITES*10-1:0]   spr_x,
    input  logic [NUM_SPRITES*10-1:0]   spr_y,
    input  logic [NUM_SPRITES-1:0]      spr_en,
    input  logic [NUM_SPRITES*2-1:0]    spr_tint,
    input  logic [NUM_SPRITES-1:0]      spr_hit,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_addr,
    input  logic [NUM_SPRITES*12-1:0]   spr_pixel,
    input  logic                        ovl_valid,
    input  logic [11:0]                 ovl_pixel,
    output logic [NUM_SPRITES-1:0]      flash_active,
    output logic [11:0]                 rgb
);

    localparam logic [9:0] WMASK = 10'(SPR_W - 1);
    localparam logic [9:0] HMASK = 10'(SPR_H - 1);

    logic [NUM_SPRITES-1:0] in_s0, in_q, blink;
    logic                   bright_q;
    logic [2:0]             hsub_q;
    logic [9:0]             vcnt_q;
    logic [11:0]            bg, rgb_d, rgb_q;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        logic [9:0] x, y;
        assign x = spr_x[i*10 +: 10];
        assign y = spr_y[i*10 +: 10];

        // right/bottom edges at 11 bits so sprites near 1023 do not wrap
        assign in_s0[i] = spr_en[i]
                        && (hCount >= x)
                        && ({1'b0, hCount} < ({1'b0, x} + 11'(SPR_W)))
                        && (vCount >= y)
                        && ({1'b0, vCount} < ({1'b0, y} + 11'(SPR_H)));

        assign spr_addr[i*ADDR_W +: ADDR_W] = (in_s0[i] && !rst)
            ? ADDR_W'((((vCount - y) & HMASK) * SPR_W) + ((hCount - x) & WMASK))
            : '0;

        sprite_flash_timer #(
            .FLASH_FRAMES(FLASH_FRAMES)
        ) u_flash (
            .clk          (clk),
            .rst          (rst),
            .frame_start_i(frame_start),
            .hit_i        (spr_hit[i]),
            .blink_o      (blink[i]),
            .active_o     (flash_active[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q     <= '0;
            bright_q <= 1'b0;
            hsub_q   <= 3'd0;
            vcnt_q   <= 10'd0;
            rgb_q    <= BLACK;
        end else begin
            in_q     <= in_s0;
            bright_q <= bright;
            hsub_q   <= hCount[3:1];
            vcnt_q   <= vCount;
            rgb_q    <= rgb_d;
        end
    end

    always_comb begin
        logic [4:0] g5;
        logic [3:0] g, b;
        g5 = 5'd10 + {3'd0, vcnt_q[6:5]}
           + {4'd0, (hsub_q == 3'b010) || (hsub_q == 3'b101)};
        g  = (g5 > 5'd15) ? 4'hF : g5[3:0];
        b  = (vcnt_q[4] ^ hsub_q[1]) ? 4'd2 : 4'd1;
        if (vcnt_q < 10'(HORIZON)) begin
            bg = {8'h00, (vcnt_q >= 10'd256) ? 4'hF : vcnt_q[7:4]};
        end else begin
            bg = {4'h0, g, b};
        end
    end

    // reverse scan: the last opaque hit written is the lowest index
    always_comb begin
        rgb_d = BLACK;
        if (!bright_q) begin
            rgb_d = BLACK;
        end else if (ovl_valid && (ovl_pixel != OVL_KEY)) begin
            rgb_d = ovl_pixel;
        end else begin
            rgb_d = bg;
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (in_q[i] && !is_key(spr_pixel[i*12 +: 12])) begin
                    if (spr_tint[i*2 +: 2] == TINT_SHIELD) begin
                        rgb_d = PURPLE;
                    end else if (flash_active[i] && blink[i]) begin
                        rgb_d = RED;
                    end else if (spr_tint[i*2 +: 2] == TINT_RED) begin
                        rgb_d = RED;
                    end else begin
                        rgb_d = spr_pixel[i*12 +: 12];
                    end
                end
            end
        end
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Directed vector table plus flash and reset sequences for the compositor.
module tb_vga_layer_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        bright;
    logic [9:0]  hCount, vCount;
    logic        frame_start;
    logic [19:0] spr_x, spr_y;
    logic [1:0]  spr_en, spr_hit, flash_active;
    logic [3:0]  spr_tint;
    logic [27:0] spr_addr;
    logic [23:0] spr_pixel;
    logic        ovl_valid;
    logic [11:0] ovl_pixel, rgb;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    vga_layer_compositor dut (
        .clk         (clk),
        .rst         (rst),
        .bright      (bright),
        .hCount      (hCount),
        .vCount      (vCount),
        .frame_start (frame_start),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .spr_tint    (spr_tint),
        .spr_hit     (spr_hit),
        .spr_addr    (spr_addr),
        .spr_pixel   (spr_pixel),
        .ovl_valid   (ovl_valid),
        .ovl_pixel   (ovl_pixel),
        .flash_active(flash_active),
        .rgb         (rgb)
    );

    typedef struct {
        logic [9:0]  x0, y0, hc, vc;
        logic        br;
        logic [1:0]  en;
        logic [3:0]  tint;
        logic [11:0] p0, p1;
        logic        ov;
        logic [11:0] op;
        logic [13:0] a0, a1;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t v[NV];

    function automatic vec_t mkv(int x0, int y0, int hc, int vc, int br,
                                 int en, int tint, int p0, int p1, int ov,
                                 int op, int a0, int a1, int e);
        vec_t r;
        r.x0 = 10'(x0); r.y0 = 10'(y0); r.hc = 10'(hc); r.vc = 10'(vc);
        r.br = 1'(br);  r.en = 2'(en);  r.tint = 4'(tint);
        r.p0 = 12'(p0); r.p1 = 12'(p1); r.ov = 1'(ov); r.op = 12'(op);
        r.a0 = 14'(a0); r.a1 = 14'(a1); r.exp = 12'(e);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic pulse(input logic fs, input logic [1:0] hit);
        frame_start = fs;
        spr_hit     = hit;
        @(posedge clk); #1;
        frame_start = 1'b0;
        spr_hit     = 2'b00;
    endtask

    // sprite 1 pixel at (210,305); stage-0 inputs already held
    task automatic pix1(input logic [11:0] p1, input logic [11:0] exp,
                        input string nm);
        @(posedge clk); #1;
        spr_pixel = {p1, 12'h000};
        @(posedge clk); #1;
        check(nm, 32'(rgb), 32'(exp));
    endtask

    initial begin
        v[0]  = mkv(200, 300, 210, 305, 1, 3, 'h0, 'h123, 'h456, 0, 'h000,   650, 3260, 'h123);
        v[1]  = mkv(200, 300, 210, 305, 1, 3, 'h0, 'h00D, 'h456, 0, 'h000,   650, 3260, 'h456);
        v[2]  = mkv(200, 300, 210, 305, 1, 3, 'h0, 'h00C, 'h00F, 0, 'h000,   650, 3260, 'h00F);
        v[3]  = mkv(200, 300, 210, 305, 1, 2, 'h0, 'h123, 'h456, 0, 'h000,     0, 3260, 'h456);
        v[4]  = mkv(200, 300, 210, 305, 1, 3, 'h0, 'h123, 'h456, 1, 'h0F0,   650, 3260, 'h0F0);
        v[5]  = mkv(200, 300, 210, 305, 1, 3, 'h0, 'h123, 'h456, 1, 'h0AF,   650, 3260, 'h123);
        v[6]  = mkv(200, 300, 210, 305, 0, 3, 'h0, 'h123, 'h456, 1, 'h0F0,   650, 3260, 'h000);
        v[7]  = mkv(200, 300, 210, 305, 1, 3, 'h1, 'h123, 'h456, 0, 'h000,   650, 3260, 'hF0F);
        v[8]  = mkv(200, 300, 210, 305, 1, 3, 'h2, 'h123, 'h456, 0, 'h000,   650, 3260, 'hF00);
        v[9]  = mkv(200, 300, 210, 305, 1, 3, 'h3, 'h123, 'h456, 0, 'h000,   650, 3260, 'h123);
        v[10] = mkv(200, 300, 210, 100, 1, 3, 'h0, 'h123, 'h456, 0, 'h000,     0,    0, 'h006);
        v[11] = mkv(960, 300, 1000, 305, 1, 1, 'h0, 'h0AB, 'h456, 0, 'h000,  680,    0, 'h0AB);
        v[12] = mkv(200, 300, 327, 305, 1, 1, 'h0, 'h321, 'h456, 0, 'h000,   767,    0, 'h321);
        v[13] = mkv(200, 300, 328, 305, 1, 1, 'h0, 'h321, 'h456, 0, 'h000,     0,    0, 'h00F);
        v[14] = mkv(200, 300, 210, 427, 1, 1, 'h0, 'h777, 'h456, 0, 'h000, 16266,    0, 'h777);
        v[15] = mkv(200, 300, 210, 428, 1, 1, 'h0, 'h777, 'h456, 0, 'h000,     0,    0, 'h0B1);
        v[16] = mkv(200, 300,   0, 393, 1, 0, 'h0, 'h000, 'h000, 0, 'h000,     0,    0, 'h00F);
        v[17] = mkv(200, 300,   0, 394, 1, 0, 'h0, 'h000, 'h000, 0, 'h000,     0,    0, 'h0A1);
        v[18] = mkv(200, 300,   4, 420, 1, 0, 'h0, 'h000, 'h000, 0, 'h000,     0,    0, 'h0C2);
        v[19] = mkv(200, 300,   4, 400, 1, 0, 'h0, 'h000, 'h000, 0, 'h000,     0,    0, 'h0B1);
        v[20] = mkv(200, 300,  10, 480, 1, 0, 'h0, 'h000, 'h000, 0, 'h000,     0,    0, 'h0E1);

        rst = 1'b1; bright = 1'b1; frame_start = 1'b0; spr_hit = 2'b00;
        hCount = 10'd210; vCount = 10'd305;
        spr_x = {10'd150, 10'd200}; spr_y = {10'd280, 10'd300};
        spr_en = 2'b11; spr_tint = 4'h0; spr_pixel = {12'h456, 12'h123};
        ovl_valid = 1'b0; ovl_pixel = 12'h000;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_flash", 32'(flash_active), 32'h0);
        check("rst_addr", 32'(spr_addr), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            spr_x = {10'd150, v[i].x0};
            spr_y = {10'd280, v[i].y0};
            spr_en = v[i].en; spr_tint = v[i].tint;
            hCount = v[i].hc; vCount = v[i].vc; bright = v[i].br;
            #1;
            check($sformatf("v%0d_addr0", i), 32'(spr_addr[13:0]), 32'(v[i].a0));
            check($sformatf("v%0d_addr1", i), 32'(spr_addr[27:14]), 32'(v[i].a1));
            @(posedge clk); #1;
            spr_pixel = {v[i].p1, v[i].p0};
            ovl_valid = v[i].ov; ovl_pixel = v[i].op;
            @(posedge clk); #1;
            check($sformatf("v%0d_rgb", i), 32'(rgb), 32'(v[i].exp));
        end

        // flash lifetime on sprite 1
        spr_x = {10'd150, 10'd200}; spr_y = {10'd280, 10'd300};
        spr_en = 2'b10; spr_tint = 4'h0; bright = 1'b1;
        hCount = 10'd210; vCount = 10'd305; ovl_valid = 1'b0;
        pulse(1'b0, 2'b10);
        check("hit_active", 32'(flash_active), 32'h2);
        pix1(12'h456, 12'h456, "cnt16_pix");
        for (int k = 1; k <= 16; k++) begin
            int cnt;
            cnt = 16 - k;
            pulse(1'b1, 2'b00);
            check($sformatf("fs%0d_active", k), 32'(flash_active),
                  (cnt != 0) ? 32'h2 : 32'h0);
            pix1(12'h456, ((cnt >> 1) & 1) != 0 ? 12'hF00 : 12'h456,
                 $sformatf("fs%0d_pix", k));
        end

        // hit beats a simultaneous frame_start and restarts a running flash
        pulse(1'b0, 2'b10);
        repeat (13) pulse(1'b1, 2'b00);
        pix1(12'h456, 12'hF00, "cnt3_pix");
        pulse(1'b1, 2'b10);
        pix1(12'h456, 12'h456, "restart16_pix");
        repeat (14) pulse(1'b1, 2'b00);
        pix1(12'h456, 12'hF00, "restart2_pix");
        pulse(1'b1, 2'b00);
        check("restart1_active", 32'(flash_active), 32'h2);
        pulse(1'b1, 2'b00);
        check("restart0_active", 32'(flash_active), 32'h0);
        pulse(1'b1, 2'b00);
        check("hold0_active", 32'(flash_active), 32'h0);

        // shield tint wins over the flash
        spr_tint = 4'b0100;
        pulse(1'b0, 2'b10);
        for (int k = 0; k < 4; k++) begin
            pix1(12'h456, 12'hF0F, $sformatf("shield%0d_pix", k));
            pulse(1'b1, 2'b00);
        end

        // reset mid-line with a flash running and a pixel in flight
        spr_tint = 4'h0; spr_en = 2'b00;
        hCount = 10'd4; vCount = 10'd420;
        @(posedge clk); #1;
        spr_en = 2'b10; hCount = 10'd210; vCount = 10'd305;
        rst = 1'b1; frame_start = 1'b1;
        #1;
        check("midrst_addr", 32'(spr_addr), 32'h0);
        @(posedge clk); #1;
        check("midrst_rgb", 32'(rgb), 32'h0);
        check("midrst_flash", 32'(flash_active), 32'h0);
        rst = 1'b0; frame_start = 1'b0;
        @(posedge clk); #1;
        check("postrst_rgb", 32'(rgb), 32'h0);
        check("postrst_flash", 32'(flash_active), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
